keyled_cpu_oci_dct_packer: RTL

Producer side of the OCI debug compressed-trace (DCT) path. It accepts 2-bit trace atoms from the CPU trace logic and packs them LSB-first into a 30-bit accumulator with a 4-bit fill count. On a full buffer or a flush request it emits one {count, buffer} frame over a valid/ready handshake to the trace FIFO. It also drives dct_buffer/dct_count, which feed the OCI test-bench monitor.

---
 rtl/keyled_cpu_oci_dct_packer_if.sv | 27 ++
 rtl/keyled_cpu_oci_dct_packer.sv | 95 +++++++++
 2 files changed

// File: rtl/keyled_cpu_oci_dct_packer_if.sv
// Trace packer bus bundle: atom input side and frame output side.
//   atom_valid/atom_data/atom_ready : 2-bit trace atom handshake (CPU -> packer)
//   flush                           : single-cycle request to emit a partial frame
//   frame_valid/frame_data/frame_ready : {count, buffer} frame handshake (packer -> FIFO)
// slave modport is the packer; master modport is the surrounding logic.
interface keyled_cpu_oci_dct_packer_if;
  localparam int unsigned ATOM_W  = 2;
  localparam int unsigned FRAME_W = 34;

  logic               atom_valid;
  logic [ATOM_W-1:0]  atom_data;
  logic               atom_ready;
  logic               flush;
  logic               frame_valid;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_ready;

  modport slave (
    input  atom_valid, atom_data, flush, frame_ready,
    output atom_ready, frame_valid, frame_data
  );

  modport master (
    output atom_valid, atom_data, flush, frame_ready,
    input  atom_ready, frame_valid, frame_data
  );
endinterface

// File: rtl/keyled_cpu_oci_dct_packer.sv
// OCI compressed-trace packer: packs 2-bit atoms LSB-first into a 30-bit
// accumulator and emits {count, buffer} frames when full or on flush.
//   clk, reset_n : clock, async active-low reset
//   bus          : atom input / flush / frame output handshakes (slave side)
//   dct_buffer   : live accumulator contents
//   dct_count    : live accumulator fill count (0..15)
//   frame_total  : frames emitted, wraps at 16 bits
module keyled_cpu_oci_dct_packer (
  input  logic                            clk,
  input  logic                            reset_n,
  keyled_cpu_oci_dct_packer_if.slave      bus,
  output logic [29:0]                     dct_buffer,
  output logic [3:0]                      dct_count,
  output logic [15:0]                     frame_total
);
  localparam int unsigned ATOM_W  = 2;
  localparam int unsigned ATOMS   = 15;
  localparam int unsigned BUF_W   = ATOM_W * ATOMS;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TOTAL_W = 16;

  logic              flush_pend;
  logic              count_full;
  logic              count_empty;
  logic              accept;
  logic              out_free;
  logic              flush_eff;
  logic              emit;
  logic [BUF_W-1:0]  buf_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Handshake and emit decisions, all from registered state.
  assign count_full     = (dct_count == CNT_W'(ATOMS));
  assign count_empty    = (dct_count == '0);
  assign bus.atom_ready = reset_n & ~count_full;
  assign accept         = bus.atom_valid & bus.atom_ready;
  assign out_free       = ~bus.frame_valid | bus.frame_ready;
  assign flush_eff      = bus.flush | flush_pend;
  assign emit           = out_free & (count_full | (flush_eff & ~count_empty));

  // Accumulator next state: an emit clears first, so a same-cycle atom lands in slot 0.
  always_comb begin
    buf_nxt = dct_buffer;
    cnt_nxt = dct_count;
    if (emit) begin
      buf_nxt = '0;
      cnt_nxt = '0;
    end
    if (accept) begin
      for (int unsigned k = 0; k < ATOMS; k++) begin
        if (cnt_nxt == CNT_W'(k)) begin
          buf_nxt[k*ATOM_W +: ATOM_W] = bus.atom_data;
        end
      end
      cnt_nxt = cnt_nxt + CNT_W'(1);
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else begin
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;
    end
  end

  // Output frame register; a new emit overwrites a draining frame with no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.frame_valid <= 1'b0;
      bus.frame_data  <= '0;
      frame_total     <= '0;
    end else if (emit) begin
      bus.frame_valid <= 1'b1;
      bus.frame_data  <= {dct_count, dct_buffer};
      frame_total     <= frame_total + TOTAL_W'(1);
    end else if (bus.frame_valid && bus.frame_ready) begin
      bus.frame_valid <= 1'b0;
    end
  end

  // Remembers a flush that arrived while the output was blocked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else if (emit || count_empty) begin
      flush_pend <= 1'b0;
    end else if (bus.flush) begin
      flush_pend <= 1'b1;
    end
  end
endmodule
